hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Forwarding and hazard controller for the 3-stage (D / X / M) RV32I pipeline.
- Drives the operand-A mux select (`io_a_sel`) and the matching rs2 forwarding select for the instruction entering X.
- Inserts load-use stalls when load data is late, and freezes on data-memory wait.
- Keeps an internal shadow pipeline of destination-register info, so the datapath needs no extra hazard state.

Parameters:
- LOAD_LATENCY, 1, cycle in which `io_mem_out` is valid for a load. 1 = during the load's M cycle. 2 = one cycle after M (the W slot).
- XLEN_REGS, 5, register-index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_id_valid  in  1  D-stage instruction valid
- io_id_rs1  in  5  D-stage rs1 index
- io_id_rs2  in  5  D-stage rs2 index
- io_id_uses_rs1  in  1  instruction reads rs1
- io_id_uses_rs2  in  1  instruction reads rs2
- io_id_use_pc  in  1  operand A is PC (auipc/jal/branch target)
- io_id_rd  in  5  destination index
- io_id_reg_wen  in  1  instruction writes rd
- io_id_is_load  in  1  instruction is a load
- io_flush  in  1  X-stage redirect (taken branch/jump)
- io_mem_wait  in  1  data memory not ready; freeze pipeline
- io_a_sel  out  2  registered operand-A select. 0 rs1, 1 pc, 2 alu_out, 3 mem_out.
- io_b_fwd_sel  out  2  registered rs2 select. 0 rs2, 2 alu_out, 3 mem_out; 1 never driven.
- io_stall  out  1  hold PC and D register this cycle
- io_bubble_x  out  1  load a NOP into X next edge
- io_x_valid  out  1  X-stage instruction valid (shadow)

Behaviour:
- **Reset.** Synchronous and active-high: reset is sampled on the rising clock edge. After reset:
  - all shadow valids are 0;
  - `io_a_sel` = 0, `io_b_fwd_sel` = 0, `io_stall` = 0, `io_bubble_x` = 0, `io_x_valid` = 0;
  - FSM is in RUN.
  - Reset mid-stall or mid-wait returns to RUN with no pending state.
- **Shadow registers.** X, M and W each hold {valid, rd, reg_wen, is_load}. They advance D→X→M→W on every edge unless frozen.
- **Select timing.** Selects are computed combinationally from D fields against the shadows, then registered. They are therefore valid for the whole X cycle of that instruction (1-cycle latency).
- **Operand match rule.** An operand matches a producer when all of these hold: uses = 1, index ≠ 0, producer valid, producer reg_wen, producer rd = index. The youngest match wins.
  - LOAD_LATENCY = 1:
    - X-shadow match, non-load → 2;
    - X-shadow match, load → 3;
    - otherwise 0.
    - The M-shadow producer writes the regfile in the same cycle D reads it; the regfile is write-first.
  - LOAD_LATENCY = 2:
    - X-shadow match, non-load → 2;
    - X-shadow match, load → load-use stall;
    - M-shadow match, load → 3;
    - M-shadow match, non-load → 0 (already written);
    - W-shadow: regfile write-first.
- **io_a_sel override.** `io_id_use_pc` forces `io_a_sel` = 1 regardless of any match.
- **FSM states.**
  - **RUN.** Outputs are normal.
    - A load-use hazard (LOAD_LATENCY = 2 only) asserts `io_stall` and `io_bubble_x` combinationally in the same cycle. D holds; the X shadow gets valid = 0 and selects are registered as 0. The FSM moves to LU_STALL.
  - **LU_STALL.** The D instruction is re-evaluated; the load is now in M, so the select is 3 and no stall is raised. The FSM returns to RUN.
    - A back-to-back second dependent load re-enters LU_STALL by the same rule.
  - **MEM_WAIT.** Entered from any state while `io_mem_wait` = 1:
    - shadows, selects and `io_x_valid` hold;
    - `io_stall` = 1;
    - `io_bubble_x` = 0.
    - On deassertion the FSM returns to the state it held before entering MEM_WAIT.
- **Priority.** `io_mem_wait` > `io_flush` > load-use stall.
  - **Flush.** The X-shadow next gets valid = 0 and registered selects are 0. `io_bubble_x` = 1 and `io_stall` = 0; the redirect is allowed to proceed. The FSM goes to RUN.
  - **Flush during mem_wait.** It is ignored; the upstream holds `io_flush` until the wait clears.
- **Invalid D.** When `io_id_valid` = 0, a bubble enters the X shadow and selects are 0.

Decomposition:
- Package `hazard_pkg`:
  - select encodings: SEL_RS = 0, SEL_PC = 1, SEL_ALU = 2, SEL_MEM = 3;
  - FSM enum: RUN, LU_STALL, MEM_WAIT;
  - shadow-entry bundle type.
- Sub-module `fwd_match`: combinational per-operand matcher. Inputs are {uses, idx, X/M shadows, LOAD_LATENCY}; outputs are {sel, lu_hazard}. It is instantiated twice, for rs1 and rs2.

Test Plan:
1. **ALU → ALU forward.** `add x5,x1,x2` then `addi x6,x5,1` → during addi's X, `io_a_sel` = 2, `io_stall` = 0.
2. **Load forward, no stall.** LOAD_LATENCY = 1: `lw x7`; `add x8,x7,x7` → `io_a_sel` = 3, `io_b_fwd_sel` = 3, no stall cycle.
3. **Load-use stall.** LOAD_LATENCY = 2: `lw x7`; `add x8,x7,x3` →
   - one cycle with `io_stall` = 1, `io_bubble_x` = 1, `io_x_valid` next = 0;
   - then `io_a_sel` = 3, `io_b_fwd_sel` = 0.
4. **No-forward cases.**
   - Producer with rd = x0, or reg_wen = 0 → selects 0.
   - `auipc x9` with matching rs1 field → `io_a_sel` = 1.
5. **Memory wait.** `io_mem_wait` high for 3 cycles during LU_STALL →
   - `io_stall` = 1 and selects frozen for 3 cycles;
   - after release, the stall sequence completes identically to scenario 3.
6. **Flush and reset.**
   - `io_flush` in the same cycle as a load-use hazard → `io_stall` = 0, `io_bubble_x` = 1, next selects 0, FSM in RUN.
   - Reset asserted in LU_STALL → all outputs 0 next cycle.

Source files
------------

// File: rtl/hazard_fwd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared select encodings, FSM states and shadow-entry type for
//               the D/X/M forwarding and hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] SEL_RS  = 2'd0;
    localparam logic [1:0] SEL_PC  = 2'd1;
    localparam logic [1:0] SEL_ALU = 2'd2;
    localparam logic [1:0] SEL_MEM = 2'd3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_wen;
        logic                 is_load;
    } shadow_t;

    // Register x0 is hard-wired, so it can never be a forwarding source.
    function automatic logic producer_hit(input shadow_t p, input logic uses,
                                          input logic [REG_IDX_W-1:0] idx);
        return uses && (idx != '0) && p.valid && p.reg_wen && (p.rd == idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_ctrl_fwd_match.sv
`default_nettype none
// ============================================================================
// Module      : fwd_match
// Description : Per-operand matcher against the X and M shadows; returns the
//               forwarding select and a load-use hazard flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_match
    import hazard_pkg::*;
#(
    parameter int LOAD_LATENCY = 1
) (
    input  logic                 i_uses,
    input  logic [REG_IDX_W-1:0] i_idx,
    input  shadow_t              i_x,
    input  shadow_t              i_m,
    output logic [1:0]           o_sel,
    output logic                 o_lu_hazard
);

    logic w_x_hit;
    logic w_m_hit;

    always_comb begin
        w_x_hit     = producer_hit(i_x, i_uses, i_idx);
        w_m_hit     = producer_hit(i_m, i_uses, i_idx);
        o_sel       = SEL_RS;
        o_lu_hazard = 1'b0;
        if (LOAD_LATENCY == 1) begin
            // M-stage producers reach D through the write-first regfile.
            if (w_x_hit) begin
                o_sel = i_x.is_load ? SEL_MEM : SEL_ALU;
            end
        end else begin
            if (w_x_hit) begin
                if (i_x.is_load) begin
                    o_lu_hazard = 1'b1;
                end else begin
                    o_sel = SEL_ALU;
                end
            end else if (w_m_hit && i_m.is_load) begin
                o_sel = SEL_MEM;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Forwarding-select and stall controller for the 3-stage RV32I
//               pipeline, tracking producers in an internal shadow pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int XLEN_REGS    = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_id_valid,
    input  logic [XLEN_REGS-1:0] io_id_rs1,
    input  logic [XLEN_REGS-1:0] io_id_rs2,
    input  logic                 io_id_uses_rs1,
    input  logic                 io_id_uses_rs2,
    input  logic                 io_id_use_pc,
    input  logic [XLEN_REGS-1:0] io_id_rd,
    input  logic                 io_id_reg_wen,
    input  logic                 io_id_is_load,
    input  logic                 io_flush,
    input  logic                 io_mem_wait,
    output logic [1:0]           io_a_sel,
    output logic [1:0]           io_b_fwd_sel,
    output logic                 io_stall,
    output logic                 io_bubble_x,
    output logic                 io_x_valid
);

    // W-stage producers are covered by the write-first regfile, so only the
    // X and M shadows ever influence a select.
    shadow_t    r_x;
    shadow_t    r_m;
    hz_state_t  r_state;
    hz_state_t  r_resume;
    logic [1:0] r_a_sel;
    logic [1:0] r_b_sel;

    logic [1:0] w_a_match;
    logic [1:0] w_b_match;
    logic       w_a_haz;
    logic       w_b_haz;
    hz_state_t  w_cur_state;
    logic       w_lu_stall;
    logic       w_kill;
    shadow_t    w_x_next;
    logic [1:0] w_a_next;
    logic [1:0] w_b_next;

    fwd_match #(
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_match_rs1 (
        .i_uses      (io_id_uses_rs1),
        .i_idx       (io_id_rs1),
        .i_x         (r_x),
        .i_m         (r_m),
        .o_sel       (w_a_match),
        .o_lu_hazard (w_a_haz)
    );

    fwd_match #(
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_match_rs2 (
        .i_uses      (io_id_uses_rs2),
        .i_idx       (io_id_rs2),
        .i_x         (r_x),
        .i_m         (r_m),
        .o_sel       (w_b_match),
        .o_lu_hazard (w_b_haz)
    );

    always_comb begin
        // Leaving MEM_WAIT resumes the interrupted state for this cycle.
        w_cur_state = (r_state == MEM_WAIT) ? r_resume : r_state;
        w_lu_stall  = io_id_valid && (w_a_haz || w_b_haz) &&
                      (w_cur_state != LU_STALL) && !io_flush && !io_mem_wait;
        w_kill      = io_flush || w_lu_stall || !io_id_valid;

        w_x_next = '0;
        w_a_next = SEL_RS;
        w_b_next = SEL_RS;
        if (!w_kill) begin
            w_x_next.valid   = 1'b1;
            w_x_next.rd      = io_id_rd;
            w_x_next.reg_wen = io_id_reg_wen;
            w_x_next.is_load = io_id_is_load;
            w_a_next         = io_id_use_pc ? SEL_PC : w_a_match;
            w_b_next         = w_b_match;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= RUN;
            r_resume <= RUN;
            r_x      <= '0;
            r_m      <= '0;
            r_a_sel  <= SEL_RS;
            r_b_sel  <= SEL_RS;
        end else if (io_mem_wait) begin
            if (r_state != MEM_WAIT) begin
                r_resume <= r_state;
            end
            r_state <= MEM_WAIT;
        end else begin
            r_state <= w_lu_stall ? LU_STALL : RUN;
            r_m     <= r_x;
            r_x     <= w_x_next;
            r_a_sel <= w_a_next;
            r_b_sel <= w_b_next;
        end
    end

    assign io_a_sel     = r_a_sel;
    assign io_b_fwd_sel = r_b_sel;
    assign io_x_valid   = r_x.valid;
    assign io_stall     = io_mem_wait || w_lu_stall;
    assign io_bubble_x  = !io_mem_wait && (io_flush || w_lu_stall);

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Directed vector table plus randomized run against a
//               distance-based reference model, for LOAD_LATENCY 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit       u1;
        bit       u2;
        bit       pc;
        bit [4:0] rd;
        bit       wen;
        bit       ld;
    } ins_t;

    typedef struct {
        ins_t     i;
        bit       rst;
        bit       fl;
        bit       wt;
        bit [1:0] a2;
        bit [1:0] b2;
        bit       xv2;
        bit       st2;
        bit       bx2;
        bit [1:0] a1;
        bit [1:0] b1;
    } vec_t;

    typedef struct {
        bit       v;
        bit [4:0] rd;
        bit       wen;
        bit       ld;
    } ent_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_use_pc;
    logic [4:0] id_rd;
    logic       id_reg_wen;
    logic       id_is_load;
    logic       flush;
    logic       mem_wait;

    logic [1:0] a_sel1, b_sel1, a_sel2, b_sel2;
    logic       stall1, bubble1, xv1, stall2, bubble2, xv2;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    hazard_fwd_ctrl #(.LOAD_LATENCY(1), .XLEN_REGS(5)) dut1 (
        .clock(clock), .reset(reset), .io_id_valid(id_valid),
        .io_id_rs1(id_rs1), .io_id_rs2(id_rs2),
        .io_id_uses_rs1(id_uses_rs1), .io_id_uses_rs2(id_uses_rs2),
        .io_id_use_pc(id_use_pc), .io_id_rd(id_rd), .io_id_reg_wen(id_reg_wen),
        .io_id_is_load(id_is_load), .io_flush(flush), .io_mem_wait(mem_wait),
        .io_a_sel(a_sel1), .io_b_fwd_sel(b_sel1), .io_stall(stall1),
        .io_bubble_x(bubble1), .io_x_valid(xv1)
    );

    hazard_fwd_ctrl #(.LOAD_LATENCY(2), .XLEN_REGS(5)) dut2 (
        .clock(clock), .reset(reset), .io_id_valid(id_valid),
        .io_id_rs1(id_rs1), .io_id_rs2(id_rs2),
        .io_id_uses_rs1(id_uses_rs1), .io_id_uses_rs2(id_uses_rs2),
        .io_id_use_pc(id_use_pc), .io_id_rd(id_rd), .io_id_reg_wen(id_reg_wen),
        .io_id_is_load(id_is_load), .io_flush(flush), .io_mem_wait(mem_wait),
        .io_a_sel(a_sel2), .io_b_fwd_sel(b_sel2), .io_stall(stall2),
        .io_bubble_x(bubble2), .io_x_valid(xv2)
    );

    task automatic chk(input string name, input int cyc, input logic [3:0] act,
                       input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic ins_t mk_ins(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                                    input bit u1, input bit u2, input bit pc,
                                    input bit [4:0] rd, input bit wen, input bit ld);
        ins_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.pc = pc; r.rd = rd; r.wen = wen; r.ld = ld;
        return r;
    endfunction

    function automatic vec_t row(input ins_t i, input bit rst, input bit fl, input bit wt,
                                 input bit [1:0] a2, input bit [1:0] b2, input bit x2,
                                 input bit st2, input bit bx2,
                                 input bit [1:0] a1, input bit [1:0] b1);
        vec_t r;
        r.i = i; r.rst = rst; r.fl = fl; r.wt = wt;
        r.a2 = a2; r.b2 = b2; r.xv2 = x2; r.st2 = st2; r.bx2 = bx2;
        r.a1 = a1; r.b1 = b1;
        return r;
    endfunction

    task automatic drive(input ins_t i, input bit rst, input bit fl, input bit wt);
        reset       = rst;
        id_valid    = i.v;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_uses_rs1 = i.u1;
        id_uses_rs2 = i.u2;
        id_use_pc   = i.pc;
        id_rd       = i.rd;
        id_reg_wen  = i.wen;
        id_is_load  = i.ld;
        flush       = fl;
        mem_wait    = wt;
    endtask

    // Reference model: in-flight producers indexed by distance k (1 = X, 2 = M).
    ent_t     hist [1:2][0:1];
    bit [1:0] m_a  [1:2];
    bit [1:0] m_b  [1:2];
    bit       m_xv [1:2];

    function automatic void ref_sel(input int lat, input bit uses, input bit [4:0] idx,
                                    output bit [1:0] sel, output bit haz);
        bit   found;
        ent_t e;
        found = 1'b0;
        sel   = 2'd0;
        haz   = 1'b0;
        if (uses && idx != 5'd0) begin
            for (int k = 1; k <= 2; k++) begin
                e = hist[lat][k-1];
                if (!found && e.v && e.wen && e.rd == idx) begin
                    found = 1'b1;
                    // Results ready by distance k: ALU at 1, load data at LOAD_LATENCY.
                    if (!e.ld)          sel = (k == 1) ? 2'd2 : 2'd0;
                    else if (k < lat)   haz = 1'b1;
                    else if (k == lat)  sel = 2'd3;
                    else                sel = 2'd0;
                end
            end
        end
    endfunction

    task automatic rand_step(input int cyc, input bit do_chk);
        ins_t     in;
        bit       r, f, w, ha, hb, haz, kill;
        bit [1:0] sa, sb;
        logic [1:0] act_a, act_b;
        logic       act_st, act_bx, act_xv;
        in = mk_ins($urandom_range(0, 99) < 85, 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 99) < 15,
                    5'($urandom_range(0, 3)), $urandom_range(0, 99) < 75,
                    $urandom_range(0, 99) < 40);
        r = !do_chk || ($urandom_range(0, 199) == 0);
        f = $urandom_range(0, 99) < 8;
        w = $urandom_range(0, 99) < 12;
        drive(in, r, f, w);
        @(negedge clock);
        for (int lat = 1; lat <= 2; lat++) begin
            ref_sel(lat, in.u1, in.rs1, sa, ha);
            ref_sel(lat, in.u2, in.rs2, sb, hb);
            haz = (ha || hb) && in.v;
            act_a  = (lat == 1) ? a_sel1  : a_sel2;
            act_b  = (lat == 1) ? b_sel1  : b_sel2;
            act_st = (lat == 1) ? stall1  : stall2;
            act_bx = (lat == 1) ? bubble1 : bubble2;
            act_xv = (lat == 1) ? xv1     : xv2;
            if (do_chk) begin
                chk($sformatf("r_a_sel_ll%0d", lat), cyc, 4'(act_a), 4'(m_a[lat]));
                chk($sformatf("r_b_sel_ll%0d", lat), cyc, 4'(act_b), 4'(m_b[lat]));
                chk($sformatf("r_xvalid_ll%0d", lat), cyc, 4'(act_xv), 4'(m_xv[lat]));
                chk($sformatf("r_stall_ll%0d", lat), cyc, 4'(act_st), 4'(w || (haz && !f)));
                chk($sformatf("r_bubble_ll%0d", lat), cyc, 4'(act_bx), 4'(!w && (f || haz)));
            end
            if (r) begin
                hist[lat][0] = '{default: 0};
                hist[lat][1] = '{default: 0};
                m_a[lat] = 2'd0; m_b[lat] = 2'd0; m_xv[lat] = 1'b0;
            end else if (!w) begin
                kill = f || haz || !in.v;
                m_a[lat]  = kill ? 2'd0 : (in.pc ? 2'd1 : sa);
                m_b[lat]  = kill ? 2'd0 : sb;
                m_xv[lat] = !kill;
                hist[lat][1] = hist[lat][0];
                hist[lat][0] = '{v: !kill, rd: in.rd, wen: in.wen, ld: in.ld};
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        ins_t nop, add5, addi6, lw7, add877, add873, addi0, add9, st, add11, auipc, idle;

        idle   = mk_ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop    = mk_ins(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add5   = mk_ins(1, 1, 2, 1, 1, 0, 5, 1, 0);
        addi6  = mk_ins(1, 5, 0, 1, 0, 0, 6, 1, 0);
        lw7    = mk_ins(1, 1, 0, 1, 0, 0, 7, 1, 1);
        add877 = mk_ins(1, 7, 7, 1, 1, 0, 8, 1, 0);
        add873 = mk_ins(1, 7, 3, 1, 1, 0, 8, 1, 0);
        addi0  = mk_ins(1, 1, 0, 1, 0, 0, 0, 1, 0);
        add9   = mk_ins(1, 0, 0, 1, 1, 0, 9, 1, 0);
        st     = mk_ins(1, 2, 3, 1, 1, 0, 10, 0, 0);
        add11  = mk_ins(1, 10, 10, 1, 1, 0, 11, 1, 0);
        auipc  = mk_ins(1, 11, 11, 1, 0, 1, 9, 1, 0);

        //                 ins     rst fl wt  a2 b2 xv st bx  a1 b1
        tbl.push_back(row(add5,    0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(row(addi6,   0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(nop,     0, 0, 0,  2, 0, 1, 0, 0,  2, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add877,  0, 0, 0,  0, 0, 1, 1, 1,  0, 0));
        tbl.push_back(row(add877,  0, 0, 0,  0, 0, 0, 0, 0,  3, 3));
        tbl.push_back(row(nop,     0, 0, 0,  3, 3, 1, 0, 0,  0, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 1, 1, 1,  0, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 0, 0, 0,  3, 0));
        tbl.push_back(row(nop,     0, 0, 0,  3, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(addi0,   0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add9,    0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(st,      0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add11,   0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(auipc,   0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(nop,     0, 0, 0,  1, 0, 1, 0, 0,  1, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 1, 1, 1,  0, 0));
        tbl.push_back(row(add873,  0, 0, 1,  0, 0, 0, 1, 0,  3, 0));
        tbl.push_back(row(add873,  0, 0, 1,  0, 0, 0, 1, 0,  3, 0));
        tbl.push_back(row(add873,  0, 0, 1,  0, 0, 0, 1, 0,  3, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 0, 0, 0,  3, 0));
        tbl.push_back(row(nop,     0, 0, 0,  3, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add873,  0, 1, 0,  0, 0, 1, 0, 1,  0, 0));
        tbl.push_back(row(nop,     0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add873,  0, 1, 1,  0, 0, 1, 1, 0,  0, 0));
        tbl.push_back(row(add873,  0, 1, 0,  0, 0, 1, 0, 1,  0, 0));
        tbl.push_back(row(nop,     0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(row(lw7,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 1, 1, 1,  0, 0));
        tbl.push_back(row(add873,  1, 0, 0,  0, 0, 0, 0, 0,  3, 0));
        tbl.push_back(row(add873,  0, 0, 0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(row(nop,     0, 0, 0,  0, 0, 1, 0, 0,  0, 0));

        drive(idle, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        drive(idle, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("reset_a_sel_ll1",  0, 4'(a_sel1),  4'd0);
        chk("reset_b_sel_ll1",  0, 4'(b_sel1),  4'd0);
        chk("reset_xvalid_ll1", 0, 4'(xv1),     4'd0);
        chk("reset_stall_ll1",  0, 4'(stall1),  4'd0);
        chk("reset_bubble_ll1", 0, 4'(bubble1), 4'd0);
        chk("reset_a_sel_ll2",  0, 4'(a_sel2),  4'd0);
        chk("reset_b_sel_ll2",  0, 4'(b_sel2),  4'd0);
        chk("reset_xvalid_ll2", 0, 4'(xv2),     4'd0);
        chk("reset_stall_ll2",  0, 4'(stall2),  4'd0);
        chk("reset_bubble_ll2", 0, 4'(bubble2), 4'd0);
        @(posedge clock);
        #1;

        for (int n = 0; n < tbl.size(); n++) begin
            drive(tbl[n].i, tbl[n].rst, tbl[n].fl, tbl[n].wt);
            @(negedge clock);
            chk("t_a_sel_ll2",  n + 1, 4'(a_sel2),  4'(tbl[n].a2));
            chk("t_b_sel_ll2",  n + 1, 4'(b_sel2),  4'(tbl[n].b2));
            chk("t_xvalid_ll2", n + 1, 4'(xv2),     4'(tbl[n].xv2));
            chk("t_stall_ll2",  n + 1, 4'(stall2),  4'(tbl[n].st2));
            chk("t_bubble_ll2", n + 1, 4'(bubble2), 4'(tbl[n].bx2));
            chk("t_a_sel_ll1",  n + 1, 4'(a_sel1),  4'(tbl[n].a1));
            chk("t_b_sel_ll1",  n + 1, 4'(b_sel1),  4'(tbl[n].b1));
            chk("t_stall_ll1",  n + 1, 4'(stall1),  4'(tbl[n].wt));
            chk("t_bubble_ll1", n + 1, 4'(bubble1), 4'(!tbl[n].wt && tbl[n].fl));
            @(posedge clock);
            #1;
        end

        rand_step(1000, 1'b0);
        for (int c = 1; c <= 1500; c++) begin
            rand_step(1000 + c, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
